// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_master
// Description : Single-outstanding AXI4-Lite master. Takes one local command
//               (read or write), runs it on the AXI-Lite channels, measures
//               bus latency in clock cycles, and presents a local response.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 2,
    parameter int LAT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,

    // Local command interface
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_RNW,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,

    // Write address channel
    output logic                  AWVALID,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWREADY,

    // Write data channel
    output logic                  WVALID,
    output logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WREADY,

    // Write response channel
    input  logic                  BVALID,
    input  logic [RESP_WIDTH-1:0] BRESP,
    output logic                  BREADY,

    // Read address channel
    output logic                  ARVALID,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARREADY,

    // Read data channel
    input  logic                  RVALID,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [RESP_WIDTH-1:0] RRESP,
    output logic                  RREADY,

    // Local response interface
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_RNW,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic [RESP_WIDTH-1:0] RSP_RESP,
    output logic [LAT_WIDTH-1:0]  RSP_LATENCY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_rnw;
    logic [LAT_WIDTH-1:0] r_lat_cnt;

    logic [LAT_WIDTH-1:0] w_lat_next;
    logic                 w_aw_done;
    logic                 w_w_done;

    // Saturating increment; also the value latched into RSP_LATENCY so the
    // cycle in which the final handshake happens is counted.
    always_comb begin
        w_lat_next = (r_lat_cnt == {LAT_WIDTH{1'b1}}) ? r_lat_cnt
                                                       : r_lat_cnt + LAT_WIDTH'(1);
        // A channel is finished when it already handshook or handshakes now.
        w_aw_done  = !AWVALID || AWREADY;
        w_w_done   = !WVALID  || WREADY;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_rnw       <= 1'b0;
            r_lat_cnt   <= '0;
            CMD_READY   <= 1'b1;
            AWVALID     <= 1'b0;
            AWADDR      <= '0;
            WVALID      <= 1'b0;
            WDATA       <= '0;
            BREADY      <= 1'b0;
            ARVALID     <= 1'b0;
            ARADDR      <= '0;
            RREADY      <= 1'b0;
            RSP_VALID   <= 1'b0;
            RSP_RNW     <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_RESP    <= '0;
            RSP_LATENCY <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY <= 1'b0;
                        r_rnw     <= CMD_RNW;
                        r_lat_cnt <= '0;
                        if (CMD_RNW) begin
                            ARVALID <= 1'b1;
                            ARADDR  <= CMD_ADDR;
                            r_state <= RD_REQ;
                        end else begin
                            AWVALID <= 1'b1;
                            AWADDR  <= CMD_ADDR;
                            WVALID  <= 1'b1;
                            WDATA   <= CMD_WDATA;
                            r_state <= WR_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    r_lat_cnt <= w_lat_next;
                    // Each VALID drops independently on its own handshake.
                    if (AWVALID && AWREADY) begin
                        AWVALID <= 1'b0;
                    end
                    if (WVALID && WREADY) begin
                        WVALID <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        BREADY  <= 1'b1;
                        r_state <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    r_lat_cnt <= w_lat_next;
                    if (BVALID && BREADY) begin
                        BREADY      <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_RNW     <= r_rnw;
                        RSP_RDATA   <= '0;
                        RSP_RESP    <= BRESP;
                        RSP_LATENCY <= w_lat_next;
                        r_state     <= DONE;
                    end
                end

                RD_REQ: begin
                    r_lat_cnt <= w_lat_next;
                    if (ARVALID && ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        r_state <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    r_lat_cnt <= w_lat_next;
                    if (RVALID && RREADY) begin
                        RREADY      <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_RNW     <= r_rnw;
                        RSP_RDATA   <= RDATA;
                        RSP_RESP    <= RRESP;
                        RSP_LATENCY <= w_lat_next;
                        r_state     <= DONE;
                    end
                end

                DONE: begin
                    if (RSP_VALID && RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        CMD_READY <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    AWVALID   <= 1'b0;
                    WVALID    <= 1'b0;
                    BREADY    <= 1'b0;
                    ARVALID   <= 1'b0;
                    RREADY    <= 1'b0;
                    RSP_VALID <= 1'b0;
                    CMD_READY <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
